apb_dec_bridge: RTL
===================

Name: apb_dec_bridge

Overview:
- Parametrised, registered APB fan-out for the peripheral subsystem; successor to the fixed 3-slave combinational peripheral splitter.
- One APB master port to NSLV slave ports; decode on a configurable paddr bit-field; every request is registered to break the master-to-slave timing path.
- Unmapped indices and hung slaves are answered internally with pslverr.

Parameters:
NSLV, 4, number of slave ports (1..2**SEL_W)
ADDR_W, 32, paddr width
DATA_W, 32, pwdata/prdata width
SEL_LSB, 12, lowest paddr bit of the slave-select field
SEL_W, 2, width of the slave-select field
TMO_CYC, 255, max slave ACCESS cycles before forced error (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m_psel  in  1  master select
m_penable  in  1  master enable
m_paddr  in  ADDR_W  master address
m_pwrite  in  1  master write
m_pstrb  in  DATA_W/8  master byte strobes
m_pprot  in  3  master protection
m_pwdata  in  DATA_W  master write data
m_prdata  out  DATA_W  read data to master
m_pslverr  out  1  error to master
m_pready  out  1  ready to master
s_psel  out  NSLV  one-hot slave select
s_penable  out  1  shared slave enable
s_paddr  out  ADDR_W  shared slave address
s_pwrite  out  1  shared slave write
s_pstrb  out  DATA_W/8  shared slave strobes
s_pprot  out  3  shared slave protection
s_pwdata  out  DATA_W  shared slave write data
s_prdata  in  NSLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
s_pslverr  in  NSLV  per-slave error
s_pready  in  NSLV  per-slave ready

Behaviour:
- Reset: state IDLE; all outputs 0; capture registers 0; timeout counter 0.
- idx = m_paddr[SEL_LSB +: SEL_W]; unmapped when idx >= NSLV.
- States IDLE, SETUP, ACCESS, RESP.
- IDLE: when m_psel=1, capture paddr/pwrite/pstrb/pprot/pwdata/idx.
  - Mapped: -> SETUP.
  - Unmapped: -> RESP with rdata=0, err=1.
  - Capture happens on m_psel alone, whether or not m_penable is set.
- SETUP: s_psel[idx]=1, s_penable=0, s_* buses drive the captured values; -> ACCESS.
- ACCESS: s_psel[idx]=1, s_penable=1; the counter increments each cycle.
  - s_pready[idx]=1: latch s_prdata/s_pslverr of slave idx; -> RESP.
- RESP:
  - Slave side: s_psel=0 and s_penable=0.
  - Master side: m_pready=1, m_prdata and m_pslverr = latched values, for exactly one cycle; -> IDLE.
- m_pready=0 in all states except RESP. m_prdata and m_pslverr are 0 whenever m_pready=0.
- s_p* buses hold the captured values from SETUP through ACCESS, and 0 in IDLE/RESP.
- Latency (master SETUP at cycle T):
  - Mapped zero-wait slave: m_pready at T+3, i.e. 2 master wait states.
  - Each slave wait state adds 1 cycle.
  - Unmapped: m_pready at T+1, i.e. 0 wait states.
- No new capture in SETUP/ACCESS/RESP; master changes during those states are ignored.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, no response issued.
- NSLV = 2**SEL_W: unmapped path unreachable, still synthesised harmlessly.

Optional Feature:
- Macro APB_DEC_BRIDGE_TMO_EN.
- Defined: in ACCESS, when the counter reaches TMO_CYC with s_pready[idx] still 0:
  - Drop s_psel/s_penable.
  - Go to RESP with rdata=0, err=1.
  - The counter clears on entry to SETUP.
- Undefined: no counter is built; ACCESS waits indefinitely for s_pready.

Test Plan:
- Read slave 1, paddr=0x1004, slave 1 zero-wait, prdata=0xDEADBEEF:
  - s_psel=4'b0010 at T+1, s_penable=1 at T+2.
  - m_pready=1, m_prdata=0xDEADBEEF, m_pslverr=0 at T+3.
- Write slave 3, paddr=0x3010, pwdata=0x12345678, pstrb=4'hF, slave 3 inserts 2 waits:
  - s_pwdata/s_pstrb/s_paddr match across SETUP and ACCESS.
  - m_pready at T+5.
- NSLV=3, paddr=0x3000:
  - No s_psel activity.
  - m_pready=1, m_pslverr=1, m_prdata=0 at T+1.
- Slave 0 returns pslverr=1 with pready: m_pslverr=1 and s_pslverr of other slaves ignored.
- TMO_EN defined, TMO_CYC=8, slave 2 never ready:
  - s_psel drops after 8 ACCESS cycles.
  - m_pready=1, m_pslverr=1, m_prdata=0.
  - The next transfer to slave 0 completes normally.
- rst pulsed during ACCESS: all outputs 0 the same cycle; after release, a fresh read completes with standard latency.

Source files
------------

// File: rtl/apb_dec_bridge_if.sv
// APB bus bundle for apb_dec_bridge.
// NS sets the number of select/response lanes: 1 on the upstream (master) side, NSLV on the
// downstream (slave) side. The master modport is the side that issues requests; the slave
// modport is the side that answers them.
interface apb_dec_bridge_if #(
  parameter int unsigned NS     = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NS-1:0]        psel;
  logic                 penable;
  logic [ADDR_W-1:0]    paddr;
  logic                 pwrite;
  logic [DATA_W/8-1:0]  pstrb;
  logic [2:0]           pprot;
  logic [DATA_W-1:0]    pwdata;
  logic [NS*DATA_W-1:0] prdata;
  logic [NS-1:0]        pslverr;
  logic [NS-1:0]        pready;

  modport master (
    output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    input  prdata, pslverr, pready
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    output prdata, pslverr, pready
  );
endinterface

// File: rtl/apb_dec_bridge.sv
// Registered APB fan-out: one upstream APB port to NSLV downstream slaves, decoded on
// paddr[SEL_LSB +: SEL_W]. Requests are captured into registers so no combinational path runs
// from the master to the slaves. Unmapped indices are answered locally with pslverr.
// Optional: define APB_DEC_BRIDGE_TMO_EN to build an ACCESS-phase timeout that answers a hung
// slave with pslverr after TMO_CYC cycles.
module apb_dec_bridge #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned TMO_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  apb_dec_bridge_if.slave  m,
  apb_dec_bridge_if.master s
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [2:0]          prot_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SEL_W-1:0]    idx_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]  idx;
  logic              mapped;
  logic              capture;
  logic              active;
  logic              resp;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmo;

  assign idx    = m.paddr[SEL_LSB +: SEL_W];
  assign mapped = (int'(idx) < int'(NSLV));
  assign active = (state_q == StSetup) || (state_q == StAccess);
  assign resp   = (state_q == StResp);

`ifdef APB_DEC_BRIDGE_TMO_EN
  localparam int unsigned CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TMO_CYC-th ACCESS cycle; cleared while in SETUP.
  assign tmo = (cnt_q == CNT_W'(TMO_CYC - 1));

  // Next value of the ACCESS cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ACCESS cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Pick the response lane of the captured slave index.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (int'(idx_q) == i) begin
        sel_ready = s.pready[i];
        sel_err   = s.pslverr[i];
        sel_rdata = s.prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic and response latching decisions.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        // Capture on psel alone so the slave sees SETUP one cycle after the master does.
        if (m.psel[0]) begin
          capture = 1'b1;
          if (mapped) begin
            state_d = StSetup;
          end else begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (sel_ready) begin
          state_d = StResp;
          rdata_d = sel_rdata;
          err_d   = sel_err;
        end else if (tmo) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      prot_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= m.paddr;
        write_q <= m.pwrite;
        strb_q  <= m.pstrb;
        prot_q  <= m.pprot;
        wdata_q <= m.pwdata;
        idx_q   <= idx;
      end
    end
  end

  // One-hot slave select, only while SETUP or ACCESS.
  always_comb begin
    s.psel = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (active && (int'(idx_q) == i)) begin
        s.psel[i] = 1'b1;
      end
    end
  end

  // Shared slave buses carry the captured request only while a slave is selected.
  assign s.penable = (state_q == StAccess);
  assign s.paddr   = active ? addr_q  : '0;
  assign s.pwrite  = active ? write_q : 1'b0;
  assign s.pstrb   = active ? strb_q  : '0;
  assign s.pprot   = active ? prot_q  : '0;
  assign s.pwdata  = active ? wdata_q : '0;

  // Master response is a single-cycle pulse; data and error are zero otherwise.
  assign m.pready  = resp;
  assign m.prdata  = resp ? rdata_q : '0;
  assign m.pslverr = resp ? err_q   : 1'b0;

endmodule
